// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: sequential PC generator feeding a small in-order fetch queue.
// Valid redirects flush the queue and retarget the PC. A misaligned target
// enqueues a single fault entry, and the unit then halts until the next valid
// redirect.
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              IMEM_AW  = 10,
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [2:0]         npc_op,
  input  logic [XLEN-1:0]    pc_b,
  input  logic [XLEN-1:0]    pc_jal,
  input  logic [XLEN-1:0]    pc_jalr,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_pcplus4,
  output logic [31:0]        out_instr,
  output logic               out_misalign
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {S_RUN, S_FAULT, S_HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;

  // Queue storage; data is only meaningful where count says so, so it is not reset.
  logic [XLEN-1:0] ent_pc_q    [DEPTH];
  logic [XLEN-1:0] ent_pc4_q   [DEPTH];
  logic [31:0]     ent_instr_q [DEPTH];
  logic            ent_mis_q   [DEPTH];

  logic            valid_redir;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;
  logic            full;
  logic            pop;
  logic            space;
  logic            push;
  logic            push_fault;

  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign pc_plus4  = pc_q + XLEN'(4);

  // Redirect decode and target selection; reserved or sequential ops do not redirect.
  always_comb begin
    valid_redir = redirect && ((npc_op == 3'd1) || (npc_op == 3'd2) || (npc_op == 3'd3));
    case (npc_op)
      3'd1:    target = pc_b;
      3'd2:    target = pc_jal;
      default: target = pc_jalr;
    endcase
  end

  // Handshake: a redirect suppresses the pop so the flush wins cleanly.
  always_comb begin
    out_valid = (count_q != '0);
    full      = (count_q == CW'(DEPTH));
    pop       = out_valid && out_ready && !valid_redir;
    space     = !full || pop;
  end

  // Head entry, forced to zero when the queue is empty (including during reset).
  always_comb begin
    out_pc       = '0;
    out_pcplus4  = '0;
    out_instr    = '0;
    out_misalign = 1'b0;
    if (out_valid) begin
      out_pc       = ent_pc_q[rptr_q];
      out_pcplus4  = ent_pc4_q[rptr_q];
      out_instr    = ent_instr_q[rptr_q];
      out_misalign = ent_mis_q[rptr_q];
    end
  end

  // Next-state logic: redirect first, then per-state push decisions.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    push       = 1'b0;
    push_fault = 1'b0;
    if (valid_redir) begin
      pc_d    = target;
      state_d = (target[1:0] == 2'b00) ? S_RUN : S_FAULT;
    end else begin
      case (state_q)
        S_RUN: begin
          if (space) begin
            push = 1'b1;
            pc_d = pc_plus4;
          end
        end
        S_FAULT: begin
          if (space) begin
            push       = 1'b1;
            push_fault = 1'b1;
            state_d    = S_HALT;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_RUN;
      endcase
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two DEPTH makes pointers wrap naturally.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (valid_redir) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry write at the tail; a fault entry carries a NOP and the misalign flag.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_pc_q[wptr_q]    <= pc_q;
      ent_pc4_q[wptr_q]   <= pc_plus4;
      ent_instr_q[wptr_q] <= push_fault ? NOP_INSTR : imem_rdata;
      ent_mis_q[wptr_q]   <= push_fault;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: two instances (RESET_PC 0 and
// RESET_PC 0xFFFF_FFFC), ROM[i]=i, expected entries queued by the stimulus
// and consumed by per-instance monitors on accepted handshakes.
module tb_fetch_queue_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  logic        clk;
  logic        rst, rst2;
  logic        redirect, redirect2;
  logic [2:0]  npc_op, npc_op2;
  logic [31:0] pc_b, pc_jal, pc_jalr, pc_b2, pc_jal2, pc_jalr2;
  logic [9:0]  imem_addr, imem_addr2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic        out_valid, out_ready, out_misalign;
  logic        out_valid2, out_ready2, out_misalign2;
  logic [31:0] out_pc, out_pcplus4, out_instr;
  logic [31:0] out_pc2, out_pcplus42, out_instr2;

  int n_checks = 0;
  int n_pass   = 0;
  ent_t exp_q[$];
  ent_t exp_q2[$];

  assign imem_rdata  = 32'(imem_addr);
  assign imem_rdata2 = 32'(imem_addr2);

  fetch_queue_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .IMEM_AW(10), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .npc_op(npc_op),
    .pc_b(pc_b), .pc_jal(pc_jal), .pc_jalr(pc_jalr),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pcplus4(out_pcplus4), .out_instr(out_instr),
    .out_misalign(out_misalign)
  );

  fetch_queue_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .IMEM_AW(10), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst2), .redirect(redirect2), .npc_op(npc_op2),
    .pc_b(pc_b2), .pc_jal(pc_jal2), .pc_jalr(pc_jalr2),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_pc(out_pc2), .out_pcplus4(out_pcplus42), .out_instr(out_instr2),
    .out_misalign(out_misalign2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_ent(input string name, input ent_t act, input ent_t exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s pc=%h pc4=%h instr=%h mis=%0b", name, act.pc, act.pc4, act.instr, act.mis);
    end else begin
      $display("FAIL %s: got pc=%h pc4=%h instr=%h mis=%0b expected pc=%h pc4=%h instr=%h mis=%0b",
               name, act.pc, act.pc4, act.instr, act.mis, exp.pc, exp.pc4, exp.instr, exp.mis);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for instance 1: an entry is consumed on handshake unless a valid redirect flushes.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !(redirect && npc_op >= 3'd1 && npc_op <= 3'd3)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL dut1_unexpected: got pc=%h expected no entry", out_pc);
      end else begin
        chk_ent("dut1_entry", {out_pc, out_pcplus4, out_instr, out_misalign}, exp_q.pop_front());
      end
    end
  end

  // Monitor for instance 2.
  always @(negedge clk) begin
    if (!rst2 && out_valid2 && out_ready2 && !(redirect2 && npc_op2 >= 3'd1 && npc_op2 <= 3'd3)) begin
      if (exp_q2.size() == 0) begin
        n_checks++;
        $display("FAIL dut2_unexpected: got pc=%h expected no entry", out_pc2);
      end else begin
        chk_ent("dut2_entry", {out_pc2, out_pcplus42, out_instr2, out_misalign2}, exp_q2.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    redirect = 1'b0; redirect2 = 1'b0;
    npc_op = 3'd0; npc_op2 = 3'd0;
    pc_b = '0; pc_jal = '0; pc_jalr = '0;
    pc_b2 = '0; pc_jal2 = '0; pc_jalr2 = '0;
    out_ready = 1'b0; out_ready2 = 1'b0;

    // Reset state.
    tick(); tick();
    @(negedge clk);
    chk("rst_valid",     32'(out_valid), 32'd0);
    chk("rst_pc",        out_pc, 32'd0);
    chk("rst_pcplus4",   out_pcplus4, 32'd0);
    chk("rst_instr",     out_instr, 32'd0);
    chk("rst_misalign",  32'(out_misalign), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst2_valid",    32'(out_valid2), 32'd0);
    chk("rst2_imem",     32'(imem_addr2), 32'h3FF);

    // Release both; instance 2 streams with wrap-around, instance 1 stalls.
    tick();
    rst = 1'b0; rst2 = 1'b0; out_ready2 = 1'b1;
    exp_q2.push_back('{32'hFFFF_FFFC, 32'h0000_0000, 32'h3FF, 1'b0});
    exp_q2.push_back('{32'h0000_0000, 32'h0000_0004, 32'h000, 1'b0});
    exp_q2.push_back('{32'h0000_0004, 32'h0000_0008, 32'h001, 1'b0});
    exp_q2.push_back('{32'h0000_0008, 32'h0000_000C, 32'h002, 1'b0});
    exp_q2.push_back('{32'h0000_000C, 32'h0000_0010, 32'h003, 1'b0});
    exp_q.push_back('{32'h0, 32'h4, 32'h0, 1'b0});
    exp_q.push_back('{32'h4, 32'h8, 32'h1, 1'b0});
    exp_q.push_back('{32'h8, 32'hC, 32'h2, 1'b0});

    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 2) begin
        redirect2 = 1'b1; npc_op2 = 3'd5;
        pc_b2 = 32'h500; pc_jal2 = 32'h500; pc_jalr2 = 32'h500;
      end
      if (i == 3) redirect2 = 1'b0;
      if (i == 5) out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("stall_valid_c%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("stall_head_c%0d", i), out_pc, 32'd0);
    end
    chk("stall_pc_hold", 32'(imem_addr), 32'd2);

    // Full queue draining while refilling: no gaps.
    tick(); out_ready2 = 1'b0;
    @(negedge clk); chk("nogap_1", 32'(out_valid), 32'd1);
    tick();
    @(negedge clk); chk("nogap_2", 32'(out_valid), 32'd1);

    // jal redirect while two entries are queued.
    tick(); redirect = 1'b1; npc_op = 3'd2; pc_jal = 32'h100;
    tick(); redirect = 1'b0;
    exp_q.push_back('{32'h100, 32'h104, 32'h40, 1'b0});
    exp_q.push_back('{32'h104, 32'h108, 32'h41, 1'b0});
    @(negedge clk);
    chk("jal_flush_valid", 32'(out_valid), 32'd0);
    chk("jal_target_addr", 32'(imem_addr), 32'h40);
    tick(); tick();

    // jalr to a misaligned target: one fault entry, then halt.
    tick(); redirect = 1'b1; npc_op = 3'd3; pc_jalr = 32'h102;
    tick(); redirect = 1'b0;
    exp_q.push_back('{32'h102, 32'h106, 32'h13, 1'b1});
    @(negedge clk); chk("jalr_flush_valid", 32'(out_valid), 32'd0);
    tick();
    tick();
    @(negedge clk); chk("halt_valid_1", 32'(out_valid), 32'd0);
    tick(); redirect = 1'b1; npc_op = 3'd0; pc_b = 32'h200;
    @(negedge clk); chk("halt_ignore_op0", 32'(out_valid), 32'd0);
    tick(); npc_op = 3'd7;
    @(negedge clk); chk("halt_ignore_op7", 32'(out_valid), 32'd0);
    tick(); npc_op = 3'd1;
    @(negedge clk); chk("halt_valid_2", 32'(out_valid), 32'd0);

    // Branch redirect resumes fetch at 0x200.
    tick(); redirect = 1'b0; npc_op = 3'd0;
    exp_q.push_back('{32'h200, 32'h204, 32'h80, 1'b0});
    exp_q.push_back('{32'h204, 32'h208, 32'h81, 1'b0});
    @(negedge clk);
    chk("branch_valid", 32'(out_valid), 32'd0);
    chk("branch_addr", 32'(imem_addr), 32'h80);
    tick(); tick();
    tick(); out_ready = 1'b0;
    tick();

    // Reset mid-operation together with a redirect.
    rst = 1'b1; redirect = 1'b1; npc_op = 3'd2; pc_jal = 32'h300;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_pc", out_pc, 32'd0);
    chk("midrst_instr", out_instr, 32'd0);
    chk("midrst_addr", 32'(imem_addr), 32'd0);
    tick();
    tick(); rst = 1'b0; redirect = 1'b0; npc_op = 3'd0; out_ready = 1'b1;
    exp_q.push_back('{32'h0, 32'h4, 32'h0, 1'b0});
    exp_q.push_back('{32'h4, 32'h8, 32'h1, 1'b0});
    tick(); tick();
    tick(); out_ready = 1'b0;
    tick(); tick();

    chk("dut1_all_delivered", 32'(exp_q.size()), 32'd0);
    chk("dut2_all_delivered", 32'(exp_q2.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning address/data width of PC and instruction.
REQ-002 The module SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-003 The module SHALL have parameter IMEM_AW, default 10, meaning instruction-memory word-address width.
REQ-004 The module SHALL have parameter DEPTH, default 2, meaning fetch-queue entries (power of two, >=2).
REQ-005 The module SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, async active-high reset.
REQ-006 The module SHALL have the port redirect, input, 1 bit: strobe qualifying npc_op.
REQ-007 The module SHALL have the port npc_op, input, 3 bits: 0 seq, 1 branch, 2 jal, 3 jalr, 4-7 reserved.
REQ-008 The module SHALL have the ports pc_b, pc_jal and pc_jalr, input, XLEN bits each: redirect targets.
REQ-009 The module SHALL have the port imem_addr, output, IMEM_AW bits: word address to async-read instruction ROM.
REQ-010 The module SHALL have the port imem_rdata, input, 32 bits: ROM data, same-cycle combinational.
REQ-011 The module SHALL have the ports out_valid (output, 1) and out_ready (input, 1): decode handshake.
REQ-012 The module SHALL have the ports out_pc and out_pcplus4 (output, XLEN each) and out_instr (output, 32): head entry.
REQ-013 The module SHALL have the port out_misalign, output, 1 bit: head entry is a misaligned-target fault.

Function
REQ-014 imem_addr SHALL equal pc[IMEM_AW+1:2] combinationally.
REQ-015 pc+4 SHALL be computed modulo 2^XLEN; 0xFFFF_FFFC+4 SHALL wrap to 0.
REQ-016 The FSM SHALL have states RUN, FAULT and HALT.
REQ-017 A push SHALL occur in RUN when the queue is not full, or is full and pops in the same cycle; it SHALL enqueue {pc, pc+4, imem_rdata, misalign=0} and set pc<=pc+4.
REQ-018 A pop SHALL occur when out_valid&&out_ready; out_* SHALL present the head entry, and out_valid SHALL equal (count!=0).
REQ-019 A simultaneous push and pop SHALL leave count unchanged; no overflow or underflow SHALL occur.
REQ-020 A valid redirect SHALL be redirect=1 with npc_op in {1,2,3}; redirect with npc_op 0 or 4-7 SHALL be ignored.
REQ-021 A valid redirect SHALL have top priority in any state: the queue is flushed (count=0), no push or pop takes effect that cycle, and pc<=selected target.
REQ-022 On a valid redirect with target[1:0]==0, the next state SHALL be RUN; first fetch from the target SHALL occur on the following cycle (redirect-to-fetch latency 1).
REQ-023 On a valid redirect with target[1:0]!=0, the next state SHALL be FAULT.
REQ-024 In FAULT, the unit SHALL push one entry {pc, pc+4, 32'h0000_0013, misalign=1} when space allows, then go to HALT.
REQ-025 In HALT, no pushes SHALL occur and pops SHALL continue; the unit SHALL leave HALT only via a valid redirect.
REQ-026 The queue pointers SHALL wrap modulo DEPTH.

Reset
REQ-027 While rst=1, asynchronously: pc=RESET_PC, count=0, pointers=0, state=RUN, out_valid=0.
REQ-028 While rst=1, out_pc, out_pcplus4, out_instr and out_misalign SHALL read 0.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries and any same-cycle redirect.
REQ-030 After rst deasserts, the first push SHALL fetch from RESET_PC on the first rising edge.

Verification
REQ-031 Reset release, out_ready=1, ROM[i]=i -> successive accepted entries pc=0,4,8 with instr 0,1,2 and pcplus4=pc+4.
REQ-032 out_ready=0 for 5 cycles with DEPTH=2 -> exactly 2 entries queued (pc 0,4), pc holds at 8, out_pc stays 0; then out_ready=1 -> pc 0,4,8 delivered in order with no gaps.
REQ-033 Queue full with simultaneous pop -> push proceeds and count stays DEPTH.
REQ-034 redirect=1, npc_op=2, pc_jal=0x100 while 2 entries are queued -> next cycle out_valid=0; following entries pc=0x100, 0x104.
REQ-035 redirect=1, npc_op=3, pc_jalr=0x102 -> one entry with out_misalign=1, out_pc=0x102, out_instr=0x00000013, then no further entries until redirect npc_op=1, pc_b=0x200 resumes fetch at 0x200.
REQ-036 RESET_PC=0xFFFF_FFFC -> first entry has pcplus4=0 and the second entry has pc=0; redirect with npc_op=5 -> ignored, sequential fetch continues.
